// File: rtl/riscv_test_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_test_pkg : shared FSM encoding and instruction constants for the   |
// |                  riscv_test_sequencer slice.               rev 1.0       |
// +--------------------------------------------------------------------------+
package riscv_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PAD     = 3'd2,
        S_RUN     = 3'd3,
        S_CHK_REQ = 3'd4,
        S_CHK_CMP = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] JAL_SELF = 32'h0000_006F;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_test_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_test_sequencer_if : program/expected-value streams, imem, CPU and  |
// |                           status signals of the test sequencer. rev 1.0  |
// +--------------------------------------------------------------------------+
interface riscv_test_sequencer_if #(
    parameter int PROG_DEPTH = 1024,
    parameter int AW         = $clog2(PROG_DEPTH)
);
    logic          start;
    logic          prog_valid;
    logic          prog_ready;
    logic          prog_last;
    logic [31:0]   prog_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic [31:0]   cpu_pc;
    logic          exp_valid;
    logic          exp_ready;
    logic          exp_last;
    logic [4:0]    exp_reg;
    logic [31:0]   exp_value;
    logic [4:0]    rf_raddr;
    logic [31:0]   rf_rdata;
    logic          done;
    logic          pass;
    logic          timeout;
    logic          overflow;
    logic [15:0]   fail_count;
    logic [4:0]    first_fail_reg;
    logic [31:0]   first_fail_got;

    modport master (
        input  start, prog_valid, prog_last, prog_data, cpu_pc,
               exp_valid, exp_last, exp_reg, exp_value, rf_rdata,
        output prog_ready, imem_we, imem_addr, imem_wdata, cpu_rst,
               exp_ready, rf_raddr, done, pass, timeout, overflow,
               fail_count, first_fail_reg, first_fail_got
    );

    modport slave (
        output start, prog_valid, prog_last, prog_data, cpu_pc,
               exp_valid, exp_last, exp_reg, exp_value, rf_rdata,
        input  prog_ready, imem_we, imem_addr, imem_wdata, cpu_rst,
               exp_ready, rf_raddr, done, pass, timeout, overflow,
               fail_count, first_fail_reg, first_fail_got
    );
endinterface
`default_nettype wire

// File: rtl/riscv_test_sequencer_stability_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stability_detector : flags a value unchanged for COUNT consecutive       |
// |                      enabled cycles.                       rev 1.0       |
// +--------------------------------------------------------------------------+
module stability_detector #(
    parameter int WIDTH = 32,
    parameter int COUNT = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_value,
    output logic                  o_stable
);
    localparam int             CW       = $clog2(COUNT + 1);
    localparam logic [CW-1:0]  C_TARGET = CW'(COUNT - 1);

    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_value;
            if (!i_en || (i_value != r_prev)) begin
                r_cnt <= '0;
            end else if (r_cnt != C_TARGET) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = i_en && (r_cnt == C_TARGET);

endmodule
`default_nettype wire

// File: rtl/riscv_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_test_sequencer : loads a program into imem, runs the CPU to its    |
// |                        halt loop and checks the register file. rev 1.0   |
// +--------------------------------------------------------------------------+
module riscv_test_sequencer #(
    parameter int          PROG_DEPTH  = 1024,
    parameter int          HALT_STABLE = 8,
    parameter int          MAX_CYCLES  = 4096,
    parameter logic [31:0] NOP_WORD    = riscv_test_pkg::NOP_WORD
) (
    input  wire logic              clk,
    input  wire logic              rst,
    riscv_test_sequencer_if.master bus
);
    import riscv_test_pkg::*;

    localparam int            AW          = $clog2(PROG_DEPTH);
    localparam int            RW          = $clog2(MAX_CYCLES);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(PROG_DEPTH - 1);
    localparam logic [RW-1:0] C_RUN_LAST  = RW'(MAX_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [RW-1:0] r_run_cnt;
    logic          r_imem_we;
    logic [AW-1:0] r_imem_addr;
    logic [31:0]   r_imem_wdata;
    logic          r_cpu_rst;
    logic          r_pass;
    logic          r_timeout;
    logic          r_overflow;
    logic [15:0]   r_fail_count;
    logic [4:0]    r_ff_reg;
    logic [31:0]   r_ff_got;
    logic [31:0]   r_exp_value;
    logic          r_exp_last;

    logic          w_prog_ready;
    logic          w_exp_ready;
    logic [4:0]    w_rf_raddr;
    logic          w_done;
    logic          w_prog_fire;
    logic          w_at_last;
    logic          w_mismatch;
    logic          w_run_en;
    logic          w_halted;

    assign w_run_en = (r_state == S_RUN);

    stability_detector #(
        .WIDTH (32),
        .COUNT (HALT_STABLE)
    ) u_stability (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_run_en),
        .i_value  (bus.cpu_pc),
        .o_stable (w_halted)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_prog_ready = 1'b0;
        w_exp_ready  = 1'b0;
        w_rf_raddr   = 5'd0;
        w_done       = 1'b0;
        w_at_last    = (r_addr == C_LAST_ADDR);
        w_mismatch   = (bus.rf_rdata != r_exp_value);
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_prog_ready = 1'b1;
                if (bus.prog_valid) begin
                    if (bus.prog_last) begin
                        w_state_next = w_at_last ? S_RUN : S_PAD;
                    end else if (w_at_last) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_PAD: begin
                if (w_at_last) w_state_next = S_RUN;
            end
            S_RUN: begin
                // A halt seen on the final budget cycle still wins over timeout.
                if (w_halted) begin
                    w_state_next = S_CHK_REQ;
                end else if (r_run_cnt == C_RUN_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_CHK_REQ: begin
                if (bus.exp_valid) begin
                    w_rf_raddr   = bus.exp_reg;
                    w_state_next = S_CHK_CMP;
                end
            end
            S_CHK_CMP: begin
                w_exp_ready  = 1'b1;
                w_state_next = r_exp_last ? S_DONE : S_CHK_REQ;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_state_next = S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_prog_fire = w_prog_ready && bus.prog_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr       <= '0;
            r_run_cnt    <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_overflow   <= 1'b0;
            r_fail_count <= '0;
            r_ff_reg     <= '0;
            r_ff_got     <= '0;
            r_exp_value  <= '0;
            r_exp_last   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            r_run_cnt <= '0;
            // Release lags entry to RUN by one cycle so the final imem write lands first.
            r_cpu_rst <= !(r_state inside {S_RUN, S_CHK_REQ, S_CHK_CMP});
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_addr       <= '0;
                        r_pass       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_fail_count <= '0;
                        r_ff_reg     <= '0;
                        r_ff_got     <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_prog_fire) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_addr;
                        r_imem_wdata <= bus.prog_data;
                        r_addr       <= r_addr + AW'(1);
                        if (!bus.prog_last && w_at_last) r_overflow <= 1'b1;
                    end
                end
                S_PAD: begin
                    r_imem_we    <= 1'b1;
                    r_imem_addr  <= r_addr;
                    r_imem_wdata <= NOP_WORD;
                    r_addr       <= r_addr + AW'(1);
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + RW'(1);
                    if (!w_halted && (r_run_cnt == C_RUN_LAST)) r_timeout <= 1'b1;
                end
                S_CHK_REQ: begin
                    if (bus.exp_valid) begin
                        r_exp_value <= bus.exp_value;
                        r_exp_last  <= bus.exp_last;
                    end
                end
                S_CHK_CMP: begin
                    if (w_mismatch) begin
                        r_fail_count <= sat_inc16(r_fail_count);
                        if (r_fail_count == 16'd0) begin
                            r_ff_reg <= r_ff_reg_next();
                            r_ff_got <= bus.rf_rdata;
                        end
                    end
                    if (r_exp_last) r_pass <= !w_mismatch && (r_fail_count == 16'd0);
                end
                default: ;
            endcase
        end
    end

    // Register index of the beat under comparison is still on the held stream.
    function automatic logic [4:0] r_ff_reg_next();
        return bus.exp_reg;
    endfunction

    assign bus.prog_ready     = w_prog_ready;
    assign bus.exp_ready      = w_exp_ready;
    assign bus.rf_raddr       = w_rf_raddr;
    assign bus.done           = w_done;
    assign bus.imem_we        = r_imem_we;
    assign bus.imem_addr      = r_imem_addr;
    assign bus.imem_wdata     = r_imem_wdata;
    assign bus.cpu_rst        = r_cpu_rst;
    assign bus.pass           = r_pass;
    assign bus.timeout        = r_timeout;
    assign bus.overflow       = r_overflow;
    assign bus.fail_count     = r_fail_count;
    assign bus.first_fail_reg = r_ff_reg;
    assign bus.first_fail_got = r_ff_got;

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_test_sequencer : scoreboard bench with a PC-walking CPU stub.   |
// |                                                            rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_riscv_test_sequencer;
    import riscv_test_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int SDEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_test_sequencer_if #(.PROG_DEPTH(DEPTH))  m ();
    riscv_test_sequencer_if #(.PROG_DEPTH(SDEPTH)) s ();

    riscv_test_sequencer #(.PROG_DEPTH(DEPTH), .HALT_STABLE(8), .MAX_CYCLES(4096),
                           .NOP_WORD(32'h0000_0013))
        dut (.clk(clk), .rst(rst), .bus(m.master));

    riscv_test_sequencer #(.PROG_DEPTH(SDEPTH), .HALT_STABLE(8), .MAX_CYCLES(4096),
                           .NOP_WORD(32'h0000_0013))
        dut_small (.clk(clk), .rst(rst), .bus(s.master));

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic        overflow;
        logic [15:0] fail_count;
        logic [4:0]  ffr;
        logic [31:0] ffg;
    } res_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    res_t res_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pad_from = DEPTH;
    int   pad_seen = 0;
    bit   rnd_mode = 0;

    logic [31:0] alu_prog [17] = '{
        32'h00100093, 32'h00200113, 32'h00300193, 32'h402082B3,
        32'h0020F333, 32'h00208233, 32'h0020E3B3, 32'h0020C433,
        32'h002094B3, 32'h0022D533, 32'h4022D5B3, 32'h0012A633,
        32'h0050B6B3, 32'h00000013, 32'h00000013, 32'h00000013,
        32'h0000006F };
    logic [4:0]  ex_reg [10] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
    logic [31:0] ex_val [10] = '{32'd3, 32'hFFFFFFFF, 32'd0, 32'd3, 32'd3, 32'd4,
                                 32'h3FFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // CPU stub: walks the PC through imem until it fetches the halt loop.
    logic [31:0] mem [DEPTH];
    logic [31:0] rf  [32];
    logic [31:0] pc = 32'd0;
    always @(posedge clk) begin
        if (m.imem_we === 1'b1) mem[m.imem_addr] <= m.imem_wdata;
        if (m.cpu_rst !== 1'b0)             pc <= 32'd0;
        else if (mem[pc[11:2]] != JAL_SELF) pc <= pc + 32'd4;
        m.rf_rdata <= rf[m.rf_raddr];
    end
    assign m.cpu_pc = pc;

    wr_t mon_w;
    always @(negedge clk) begin
        if (m.imem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL imem_unexpected: got addr %0d data 0x%08h, expected no write",
                         m.imem_addr, m.imem_wdata);
            end else begin
                mon_w = wr_q.pop_front();
                chk("imem_addr", 32'(m.imem_addr), 32'(mon_w.addr));
                chk("imem_data", m.imem_wdata, mon_w.data);
            end
            if ((32'(m.imem_addr) >= pad_from) && (m.imem_wdata == NOP_WORD)) pad_seen++;
        end
    end

    res_t mon_r;
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (m.done === 1'b1 && !done_d) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got done=1, expected no completion");
            end else begin
                mon_r = res_q.pop_front();
                chk("pass",           32'(m.pass),           32'(mon_r.pass));
                chk("timeout",        32'(m.timeout),        32'(mon_r.timeout));
                chk("overflow",       32'(m.overflow),       32'(mon_r.overflow));
                chk("fail_count",     32'(m.fail_count),     32'(mon_r.fail_count));
                chk("first_fail_reg", 32'(m.first_fail_reg), 32'(mon_r.ffr));
                chk("first_fail_got", m.first_fail_got,      mon_r.ffg);
            end
        end
        done_d = m.done;
    end

    task automatic gap();
        if (rnd_mode) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    endtask

    task automatic send_prog(input logic [31:0] w, input logic last, input int a);
        int  guard = 0;
        bit  acc = 0;
        wr_t e;
        gap();
        e.addr = 10'(a); e.data = w;
        wr_q.push_back(e);
        m.prog_valid = 1'b1; m.prog_data = w; m.prog_last = last;
        while (!acc) begin
            @(negedge clk); acc = m.prog_ready;
            @(posedge clk); #1; guard++;
            if (!acc && guard > 200) begin
                checks++; errors++;
                $display("FAIL prog_handshake: got no prog_ready within 200 cycles, expected ready");
                break;
            end
        end
        m.prog_valid = 1'b0; m.prog_last = 1'b0;
    endtask

    task automatic send_exp(input logic [4:0] r, input logic [31:0] v, input logic last);
        int guard = 0;
        bit acc = 0;
        gap();
        m.exp_valid = 1'b1; m.exp_reg = r; m.exp_value = v; m.exp_last = last;
        while (!acc) begin
            @(negedge clk); acc = m.exp_ready;
            @(posedge clk); #1; guard++;
            if (!acc && guard > 6000) begin
                checks++; errors++;
                $display("FAIL exp_handshake: got no exp_ready within 6000 cycles, expected ready");
                break;
            end
        end
        m.exp_valid = 1'b0; m.exp_last = 1'b0;
    endtask

    task automatic load_prog(input bit use_alu, input int n);
        wr_t e;
        pad_from = n;
        pad_seen = 0;
        for (int i = 0; i < n; i++) send_prog(use_alu ? alu_prog[i] : NOP_WORD, i == n - 1, i);
        for (int i = n; i < DEPTH; i++) begin
            e.addr = 10'(i); e.data = NOP_WORD;
            wr_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        m.start = 1'b1;
        @(posedge clk); #1;
        m.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (m.done !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL done_wait: got done=%b after %0d cycles, expected 1", m.done, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_rst",    32'(m.cpu_rst),        32'd1);
        chk("rst_imem_we",    32'(m.imem_we),        32'd0);
        chk("rst_prog_ready", 32'(m.prog_ready),     32'd0);
        chk("rst_exp_ready",  32'(m.exp_ready),      32'd0);
        chk("rst_done",       32'(m.done),           32'd0);
        chk("rst_pass",       32'(m.pass),           32'd0);
        chk("rst_timeout",    32'(m.timeout),        32'd0);
        chk("rst_overflow",   32'(m.overflow),       32'd0);
        chk("rst_fail_count", 32'(m.fail_count),     32'd0);
        chk("rst_ff_reg",     32'(m.first_fail_reg), 32'd0);
        chk("rst_ff_got",     m.first_fail_got,      32'd0);
        chk("rst_rf_raddr",   32'(m.rf_raddr),       32'd0);
    endtask

    task automatic run_alu(input logic [31:0] x4_val, input res_t exp_res);
        int n;
        pulse_start();
        chk("start_to_load", 32'(m.prog_ready), 32'd1);
        res_q.push_back(exp_res);
        load_prog(1'b1, 17);
        if (rnd_mode) begin
            n = 0;
            while (m.cpu_rst !== 1'b0 && n < 3000) begin @(posedge clk); #1; n++; end
            if (n >= 3000) begin
                checks++; errors++;
                $display("FAIL cpu_release: got cpu_rst=%b, expected 0 within 3000 cycles", m.cpu_rst);
            end
            pulse_start();
            chk("start_in_run_ignored", 32'(m.prog_ready), 32'd0);
        end
        for (int i = 0; i < 10; i++) send_exp(ex_reg[i], (i == 0) ? x4_val : ex_val[i], i == 9);
        wait_done(6000);
        chk("pad_writes", 32'(pad_seen), 32'd1007);
    endtask

    int sg;
    bit sa;
    res_t r_ok, r_bad, r_to;

    initial begin
        m.start = 0; m.prog_valid = 0; m.prog_last = 0; m.prog_data = 0;
        m.exp_valid = 0; m.exp_last = 0; m.exp_reg = 0; m.exp_value = 0;
        s.start = 0; s.prog_valid = 0; s.prog_last = 0; s.prog_data = 0;
        s.exp_valid = 0; s.exp_last = 0; s.exp_reg = 0; s.exp_value = 0;
        s.cpu_pc = 0; s.rf_rdata = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'd1; rf[2] = 32'd2; rf[3] = 32'd3;
        for (int i = 0; i < 10; i++) rf[ex_reg[i]] = ex_val[i];
        r_ok  = '{pass: 1'b1, timeout: 1'b0, overflow: 1'b0, fail_count: 16'd0, ffr: 5'd0, ffg: 32'd0};
        r_bad = '{pass: 1'b0, timeout: 1'b0, overflow: 1'b0, fail_count: 16'd1, ffr: 5'd4, ffg: 32'd3};
        r_to  = '{pass: 1'b0, timeout: 1'b1, overflow: 1'b0, fail_count: 16'd0, ffr: 5'd0, ffg: 32'd0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_reset_outputs();

        // Small-depth instance: the 16th beat without last must overflow.
        s.start = 1'b1; @(posedge clk); #1; s.start = 1'b0;
        for (int i = 0; i < SDEPTH; i++) begin
            s.prog_valid = 1'b1; s.prog_data = 32'h100 + 32'(i); s.prog_last = 1'b0;
            sg = 0; sa = 0;
            while (!sa) begin
                @(negedge clk); sa = s.prog_ready;
                @(posedge clk); #1; sg++;
                if (!sa && sg > 50) begin
                    checks++; errors++;
                    $display("FAIL small_handshake: got no prog_ready at beat %0d, expected ready", i);
                    break;
                end
            end
        end
        s.prog_data = 32'h999;
        chk("ovf_flag",      32'(s.overflow),  32'd1);
        chk("ovf_done",      32'(s.done),      32'd1);
        chk("ovf_pass",      32'(s.pass),      32'd0);
        chk("ovf_last_addr", 32'(s.imem_addr), 32'd15);
        repeat (3) begin
            @(negedge clk);
            chk("ovf_ready_low", 32'(s.prog_ready), 32'd0);
        end
        @(posedge clk); #1;
        s.prog_valid = 1'b0;

        run_alu(32'd3, r_ok);
        run_alu(32'd4, r_bad);

        pulse_start();
        res_q.push_back(r_to);
        load_prog(1'b0, 4);
        wait_done(7000);
        chk("pad_writes_nop", 32'(pad_seen), 32'd1020);

        rnd_mode = 1;
        run_alu(32'd3, r_ok);
        rnd_mode = 0;

        pulse_start();
        pad_from = DEPTH;
        for (int i = 0; i < 3; i++) send_prog(alu_prog[i], 1'b0, i);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_reset_outputs();
        @(negedge clk);
        chk("wr_q_after_reset", 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;
        run_alu(32'd3, r_ok);

        repeat (4) @(posedge clk);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        chk("wr_q_empty",  32'(wr_q.size()),  32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
